imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, immediate output width; legal values 32 or 64.
REQ-002 Parameter TAG_WIDTH, default 5, width of the sideband tag carried alongside each immediate.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Immediate  input  25  instruction bits [31:7].
REQ-006 ImmSrcD  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 CSR-zimm (see Configuration), 110/111 reserved.
REQ-007 TagIn  input  TAG_WIDTH  sideband tag (e.g. rd index) captured with the immediate.
REQ-008 ValidIn  input  1  upstream offers an entry.
REQ-009 ReadyOut  output  1  block can accept an entry this cycle.
REQ-010 ExtImmE  output  DATA_WIDTH  extended immediate of the head entry.
REQ-011 TagOut  output  TAG_WIDTH  tag of the head entry.
REQ-012 IllegalE  output  1  head entry used a reserved or disabled ImmSrcD encoding.
REQ-013 ValidOut  output  1  head entry valid.
REQ-014 ReadyIn  input  1  downstream accepts the head entry this cycle.
REQ-015 Flush  input  1  discard all held entries.

Function
REQ-016 Input transfer SHALL occur when ValidIn && ReadyOut; output transfer when ValidOut && ReadyIn.
REQ-017 Storage SHALL be a 2-entry skid buffer: main register (drives outputs) plus one skid register.
REQ-018 Latency SHALL be exactly 1 cycle from accepted input to ValidOut when the buffer is empty.
REQ-019 ReadyOut SHALL be a registered signal equal to NOT skid_valid; no combinational path from ReadyIn to ReadyOut.
REQ-020 Accept while main empty, or main draining this cycle with skid empty -> entry loads main.
REQ-021 Accept while main full and not draining -> entry loads skid; ReadyOut drops next cycle.
REQ-022 Main draining while skid full -> skid moves to main next cycle; ReadyOut rises next cycle.
REQ-023 Simultaneous accept and drain with main full SHALL keep ValidOut high with the new entry in main (no bubble).
REQ-024 Extension: I {sign,imm[31:20]}; S {sign,imm[31:25],imm[11:7]}; B {sign,imm[7],imm[30:25],imm[11:8],0}; J {sign,imm[19:12],imm[20],imm[30:21],0}; U {sign,imm[31:12],12'b0}; sign = Immediate[31] replicated to DATA_WIDTH.
REQ-025 Extension SHALL be computed before the register; ExtImmE is never combinationally dependent on Immediate.
REQ-026 Reserved encodings SHALL store ExtImm = 0 and IllegalE = 1; legal encodings store IllegalE = 0.
REQ-027 Flush SHALL clear main and skid valid bits next cycle; an input presented in the Flush cycle SHALL be dropped; ReadyOut = 1 the cycle after Flush.
REQ-028 Flush SHALL take priority over ReadyIn and ValidIn in the same cycle.
REQ-029 Data registers SHALL hold value while their valid bit is low or the stage is stalled (no spurious toggling).

Reset
REQ-030 While rst is high: ValidOut = 0, ReadyOut = 0, skid valid = 0, ExtImmE = 0, TagOut = 0, IllegalE = 0.
REQ-031 First cycle after rst deasserts ReadyOut SHALL be 1.
REQ-032 rst mid-operation SHALL discard all entries exactly as Flush and additionally zero the data registers; rst has priority over Flush.

Configuration
REQ-033 Macro IMM_GEN_CSR_ZIMM_EN: defined -> ImmSrcD 101 yields zero-extended Immediate[19:15], IllegalE = 0.
REQ-034 Undefined -> ImmSrcD 101 treated as reserved per REQ-026; all other behaviour identical.

Verification
REQ-035 DW=32, Immediate=0xFFF00093[31:7], ImmSrcD=000, ReadyIn=1 -> next cycle ValidOut=1, ExtImmE=0xFFFFFFFF, IllegalE=0.
REQ-036 Instr 0xFE000EE3 (B), 0x0080006F (J), 0x123450B7 (U) back-to-back, ReadyIn=1 -> ExtImmE 0xFFFFFFFC, 0x00000008, 0x12345000 on consecutive cycles, no bubbles.
REQ-037 DW=64, instr 0x80000037, ImmSrcD=100 -> ExtImmE=0xFFFFFFFF80000000.
REQ-038 ReadyIn=0, three ValidIn pulses tags 1,2,3 -> tags 1,2 held, ReadyOut=0 after second, third not accepted; ReadyIn=1 -> TagOut 1 then 2, ReadyOut=1 after tag 1 drains.
REQ-039 Buffer full, Flush=1 with ValidIn=1 -> next cycle ValidOut=0, ReadyOut=1, dropped entry never appears.
REQ-040 ImmSrcD=101, Immediate[19:15]=0x1F -> with macro ExtImmE=0x1F, IllegalE=0; without ExtImmE=0, IllegalE=1; ImmSrcD=111 -> IllegalE=1 both builds.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate extender feeding a 2-entry skid buffer.
// The extension is computed combinationally from the incoming instruction
// bits and registered, so ExtImmE never depends combinationally on Immediate.
// ReadyOut is registered (NOT skid_valid), so ReadyIn has no combinational
// path to ReadyOut.
// Optional feature: define IMM_GEN_CSR_ZIMM_EN to give ImmSrcD=101 the CSR
// zimm meaning (zero-extended instr[19:15]). When it is undefined, 101 is
// handled as a reserved encoding.
module imm_gen_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [24:0]           Immediate,
   input  logic [2:0]            ImmSrcD,
   input  logic [TAG_WIDTH-1:0]  TagIn,
   input  logic                  ValidIn,
   output logic                  ReadyOut,
   output logic [DATA_WIDTH-1:0] ExtImmE,
   output logic [TAG_WIDTH-1:0]  TagOut,
   output logic                  IllegalE,
   output logic                  ValidOut,
   input  logic                  ReadyIn,
   input  logic                  Flush
);

   localparam logic [2:0] SRC_I   = 3'b000;
   localparam logic [2:0] SRC_S   = 3'b001;
   localparam logic [2:0] SRC_B   = 3'b010;
   localparam logic [2:0] SRC_J   = 3'b011;
   localparam logic [2:0] SRC_U   = 3'b100;
   localparam logic [2:0] SRC_CSR = 3'b101;

   // Instruction bits keep their architectural indices.
   logic [31:7] ins;
   assign ins = Immediate;

   logic [DATA_WIDTH-1:0] imm_c;
   logic                  ill_c;

   // Immediate extension of the offered instruction.
   always_comb begin
      imm_c = '0;
      ill_c = 1'b0;
      case (ImmSrcD)
         SRC_I:   imm_c = DATA_WIDTH'($signed(ins[31:20]));
         SRC_S:   imm_c = DATA_WIDTH'($signed({ins[31:25], ins[11:7]}));
         SRC_B:   imm_c = DATA_WIDTH'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         SRC_J:   imm_c = DATA_WIDTH'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         SRC_U:   imm_c = DATA_WIDTH'($signed({ins[31:12], 12'b0}));
`ifdef IMM_GEN_CSR_ZIMM_EN
         SRC_CSR: imm_c = DATA_WIDTH'(ins[19:15]);
`else
         SRC_CSR: ill_c = 1'b1;
`endif
         default: ill_c = 1'b1;
      endcase
   end

   logic                  main_v_q,   main_v_d;
   logic [DATA_WIDTH-1:0] main_imm_q, main_imm_d;
   logic [TAG_WIDTH-1:0]  main_tag_q, main_tag_d;
   logic                  main_ill_q, main_ill_d;
   logic                  skid_v_q,   skid_v_d;
   logic [DATA_WIDTH-1:0] skid_imm_q, skid_imm_d;
   logic [TAG_WIDTH-1:0]  skid_tag_q, skid_tag_d;
   logic                  skid_ill_q, skid_ill_d;
   logic                  ready_q,    ready_d;

   logic in_fire;
   logic out_fire;
   assign in_fire  = ValidIn  && ready_q;
   assign out_fire = main_v_q && ReadyIn;

   // Skid buffer next state: data registers only load on a real transfer.
   always_comb begin
      main_v_d   = main_v_q;
      main_imm_d = main_imm_q;
      main_tag_d = main_tag_q;
      main_ill_d = main_ill_q;
      skid_v_d   = skid_v_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_ill_d = skid_ill_q;

      if (Flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (skid_v_q) begin
         // Skid full means ReadyOut is low, so only draining can happen.
         if (out_fire) begin
            main_v_d   = 1'b1;
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            main_ill_d = skid_ill_q;
            skid_v_d   = 1'b0;
         end
      end else if (!main_v_q || out_fire) begin
         main_v_d = in_fire;
         if (in_fire) begin
            main_imm_d = imm_c;
            main_tag_d = TagIn;
            main_ill_d = ill_c;
         end
      end else if (in_fire) begin
         skid_v_d   = 1'b1;
         skid_imm_d = imm_c;
         skid_tag_d = TagIn;
         skid_ill_d = ill_c;
      end

      ready_d = !skid_v_d;
   end

   // State registers; reset clears valid bits and zeroes payloads.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v_q   <= 1'b0;
         main_imm_q <= '0;
         main_tag_q <= '0;
         main_ill_q <= 1'b0;
         skid_v_q   <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_ill_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         main_v_q   <= main_v_d;
         main_imm_q <= main_imm_d;
         main_tag_q <= main_tag_d;
         main_ill_q <= main_ill_d;
         skid_v_q   <= skid_v_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         skid_ill_q <= skid_ill_d;
         ready_q    <= ready_d;
      end
   end

   assign ReadyOut = ready_q;
   assign ValidOut = main_v_q;
   assign ExtImmE  = main_imm_q;
   assign TagOut   = main_tag_q;
   assign IllegalE = main_ill_q;

endmodule
